// File: rtl/adc_channel_averager.sv
// adc_channel_averager: per-channel power-of-two window mean of ADC samples, with an Avalon-MM read slave
module adc_channel_averager #(
  parameter int NUM_CH   = 8,
  parameter int LOG2_AVG = 4
) (
  input  logic        clk_clk,
  input  logic        reset_reset,
  input  logic        response_valid,
  input  logic [4:0]  response_channel,
  input  logic [11:0] response_data,
  input  logic        response_startofpacket,
  input  logic        response_endofpacket,
  output logic        avg_valid,
  output logic [4:0]  avg_channel,
  output logic [11:0] avg_data,
  input  logic [3:0]  avs_address,
  input  logic        avs_read,
  output logic [15:0] avs_readdata,
  output logic        avs_readdatavalid
);
  localparam int AW = 12 + LOG2_AVG;
  logic [AW-1:0]       acc_q [NUM_CH];
  logic [AW-1:0]       acc_d [NUM_CH];
  logic [LOG2_AVG-1:0] cnt_q [NUM_CH];
  logic [LOG2_AVG-1:0] cnt_d [NUM_CH];
  logic [11:0]         res_q [NUM_CH];
  logic [11:0]         res_d [NUM_CH];
  logic [NUM_CH-1:0]   fresh_q, fresh_d;
  logic [7:0]          drop_q, drop_d;
  logic                avg_valid_q, avg_valid_d;
  logic [4:0]          avg_channel_q, avg_channel_d;
  logic [11:0]         avg_data_q, avg_data_d;
  logic [15:0]         rdata_q, rdata_d;
  logic                rdv_q, rdv_d;
  logic                unused_sop_eop;
  assign unused_sop_eop = response_startofpacket ^ response_endofpacket;
  // Reads sample the _q state, so a colliding update is invisible to that read and its set beats the read's clear.
  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    res_d = res_q;
    fresh_d = fresh_q;
    avg_valid_d = 1'b0;
    avg_channel_d = avg_channel_q;
    avg_data_d = avg_data_q;
    rdv_d = avs_read;
    rdata_d = !avs_read ? rdata_q : avs_address == 4'hf ? {8'h00, drop_q} : 16'h0000;
    drop_d = (response_valid && response_channel >= 5'(NUM_CH) && drop_q != 8'hff) ? drop_q + 8'd1 : drop_q;
    for (int c = 0; c < NUM_CH; c++) begin
      if (avs_read && avs_address == 4'(c)) begin
        rdata_d = {fresh_q[c], 3'b000, res_q[c]};
        fresh_d[c] = 1'b0;
      end
      if (response_valid && response_channel == 5'(c)) begin
        acc_d[c] = acc_q[c] + AW'(response_data);
        if (cnt_q[c] == '1) begin
          res_d[c] = 12'(acc_d[c] >> LOG2_AVG);
          fresh_d[c] = 1'b1;
          acc_d[c] = '0;
          cnt_d[c] = '0;
          avg_valid_d = 1'b1;
          avg_channel_d = response_channel;
          avg_data_d = res_d[c];
        end else begin
          cnt_d[c] = cnt_q[c] + LOG2_AVG'(1);
        end
      end
    end
  end
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      for (int c = 0; c < NUM_CH; c++) begin
        acc_q[c] <= '0;
        cnt_q[c] <= '0;
        res_q[c] <= '0;
      end
      fresh_q <= '0;
      drop_q <= '0;
      avg_valid_q <= 1'b0;
      avg_channel_q <= '0;
      avg_data_q <= '0;
      rdata_q <= '0;
      rdv_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      res_q <= res_d;
      fresh_q <= fresh_d;
      drop_q <= drop_d;
      avg_valid_q <= avg_valid_d;
      avg_channel_q <= avg_channel_d;
      avg_data_q <= avg_data_d;
      rdata_q <= rdata_d;
      rdv_q <= rdv_d;
    end
  end
  assign avg_valid = avg_valid_q;
  assign avg_channel = avg_channel_q;
  assign avg_data = avg_data_q;
  assign avs_readdata = rdata_q;
  assign avs_readdatavalid = rdv_q;
endmodule

// File: tb/tb_adc_channel_averager.sv
// tb_adc_channel_averager: scoreboard bench for the per-channel window averager and its read slave
module tb_adc_channel_averager;
  localparam int NUM_CH = 8;
  localparam int LOG2_AVG = 4;
  localparam int WIN = 1 << LOG2_AVG;
  logic clk_clk = 1'b0;
  logic reset_reset = 1'b1;
  logic response_valid = 1'b0;
  logic [4:0] response_channel = '0;
  logic [11:0] response_data = '0;
  logic response_startofpacket = 1'b0;
  logic response_endofpacket = 1'b0;
  logic avg_valid;
  logic [4:0] avg_channel;
  logic [11:0] avg_data;
  logic [3:0] avs_address = '0;
  logic avs_read = 1'b0;
  logic [15:0] avs_readdata;
  logic avs_readdatavalid;
  adc_channel_averager #(.NUM_CH(NUM_CH), .LOG2_AVG(LOG2_AVG)) dut (
    .clk_clk(clk_clk), .reset_reset(reset_reset),
    .response_valid(response_valid), .response_channel(response_channel), .response_data(response_data),
    .response_startofpacket(response_startofpacket), .response_endofpacket(response_endofpacket),
    .avg_valid(avg_valid), .avg_channel(avg_channel), .avg_data(avg_data),
    .avs_address(avs_address), .avs_read(avs_read), .avs_readdata(avs_readdata),
    .avs_readdatavalid(avs_readdatavalid)
  );
  always #5 clk_clk = ~clk_clk;
  int cyc = 0;
  always @(posedge clk_clk) cyc = cyc + 1;
  typedef struct {int ch; int data; int at;} avg_t;
  typedef struct {int data; int at;} rd_t;
  avg_t aq[$];
  rd_t rq[$];
  int m_acc[16], m_cnt[16], m_res[16], m_fresh[16], m_drop;
  int checks = 0, errors = 0;
  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_acc[i] = 0; m_cnt[i] = 0; m_res[i] = 0; m_fresh[i] = 0;
    end
    m_drop = 0;
  endtask
  // One clock of stimulus; the read expectation is taken before the sample updates the model.
  task automatic step(input bit v, input int ch, input int data, input bit r, input int addr);
    int exp;
    @(negedge clk_clk);
    response_valid = v; response_channel = 5'(ch); response_data = 12'(data);
    response_startofpacket = v && m_cnt[ch & 15] == 0; response_endofpacket = v;
    avs_read = r; avs_address = 4'(addr);
    if (r) begin
      exp = addr < NUM_CH ? (m_fresh[addr] << 15) | m_res[addr] : addr == 15 ? m_drop : 0;
      rq.push_back('{exp, cyc + 1});
      if (addr < NUM_CH) m_fresh[addr] = 0;
    end
    if (v && ch < NUM_CH) begin
      m_acc[ch] += data;
      m_cnt[ch]++;
      if (m_cnt[ch] == WIN) begin
        m_res[ch] = m_acc[ch] >> LOG2_AVG;
        m_fresh[ch] = 1;
        aq.push_back('{ch, m_res[ch], cyc + 1});
        m_acc[ch] = 0; m_cnt[ch] = 0;
      end
    end else if (v && m_drop < 255) m_drop++;
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
  endtask
  task automatic drain(input string name);
    idle(3);
    checks++;
    if (aq.size() !== 0 || rq.size() !== 0) begin
      errors++;
      $display("FAIL %s drain: pending avg=%0d reads=%0d, required 0/0", name, aq.size(), rq.size());
      aq.delete(); rq.delete();
    end
  endtask
  task automatic pulse_reset();
    @(negedge clk_clk);
    reset_reset = 1'b1; response_valid = 1'b0; avs_read = 1'b0;
    @(negedge clk_clk);
    reset_reset = 1'b0;
    model_reset();
  endtask
  always @(negedge clk_clk) begin
    if (aq.size() > 0 && aq[0].at < cyc) begin
      checks++; errors++;
      $display("FAIL avg_missing: no avg_valid strobe, required ch=%0d data=%0d at cycle %0d", aq[0].ch, aq[0].data, aq[0].at);
      void'(aq.pop_front());
    end
    if (rq.size() > 0 && rq[0].at < cyc) begin
      checks++; errors++;
      $display("FAIL read_missing: no readdatavalid, required %h at cycle %0d", rq[0].data, rq[0].at);
      void'(rq.pop_front());
    end
    if (avg_valid === 1'b1) begin
      avg_t e;
      checks++;
      if (aq.size() == 0) begin
        errors++;
        $display("FAIL avg_unexpected: got ch=%0d data=%0d at cycle %0d, required no strobe", avg_channel, avg_data, cyc);
      end else begin
        e = aq.pop_front();
        if (avg_channel !== 5'(e.ch) || avg_data !== 12'(e.data) || cyc != e.at) begin
          errors++;
          $display("FAIL avg_result: got ch=%0d data=%0d cyc=%0d, required ch=%0d data=%0d cyc=%0d",
                   avg_channel, avg_data, cyc, e.ch, e.data, e.at);
        end
      end
    end
    if (avs_readdatavalid === 1'b1) begin
      rd_t e;
      checks++;
      if (rq.size() == 0) begin
        errors++;
        $display("FAIL read_unexpected: got %h at cycle %0d, required no readdatavalid", avs_readdata, cyc);
      end else begin
        e = rq.pop_front();
        if (avs_readdata !== 16'(e.data) || cyc != e.at) begin
          errors++;
          $display("FAIL read_data: got %h cyc=%0d, required %h cyc=%0d", avs_readdata, cyc, 16'(e.data), e.at);
        end
      end
    end
  end
  task automatic test_reset();
    reset_reset = 1'b1;
    repeat (3) @(negedge clk_clk);
    checks++;
    if ({avg_valid, avg_channel, avg_data, avs_readdata, avs_readdatavalid} !== 35'd0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b ch=%h d=%h rd=%h rdv=%b, required all 0",
               avg_valid, avg_channel, avg_data, avs_readdata, avs_readdatavalid);
    end
    reset_reset = 1'b0;
    model_reset();
    for (int a = 0; a < 16; a++) step(0, 0, 0, 1, a);
    drain("reset");
  endtask
  task automatic test_constant();
    for (int i = 0; i < WIN; i++) step(1, 2, 100, 0, 0);
    step(0, 0, 0, 1, 2);
    step(0, 0, 0, 1, 2);
    drain("constant");
  endtask
  task automatic test_truncation();
    for (int i = 0; i < WIN; i++) step(1, 0, i, 0, 0);
    for (int i = 0; i < WIN; i++) step(1, 0, i == WIN - 1 ? 4094 : 4095, 0, 0);
    step(0, 0, 0, 1, 0);
    drain("truncation");
  endtask
  task automatic test_interleave();
    for (int i = 0; i < 2 * WIN; i++) step(1, i % 2 ? 3 : 1, i % 2 ? 20 : 10, 0, 0);
    for (int i = 0; i < 2 * WIN; i++) step(1, i % 4 < 2 ? 6 : 7, $urandom_range(4095), 1, i % 16);
    drain("interleave");
  endtask
  task automatic test_drop();
    pulse_reset();
    for (int i = 0; i < 3; i++) step(1, 20, 5, 0, 0);
    step(0, 0, 0, 1, 15);
    for (int i = 0; i < 300; i++) step(1, i % 3 == 0 ? NUM_CH : i % 3 == 1 ? 31 : 20, i, i % 50 == 0, 15);
    step(0, 0, 0, 1, 15);
    drain("drop");
  endtask
  task automatic test_reset_mid();
    for (int i = 0; i < WIN / 2; i++) step(1, 4, 3000, 0, 0);
    pulse_reset();
    for (int i = 0; i < WIN; i++) step(1, 4, 50, 0, 0);
    step(0, 0, 0, 1, 4);
    drain("reset_mid");
  endtask
  task automatic test_collision();
    for (int i = 0; i < WIN - 1; i++) step(1, 5, 77 + i, 0, 0);
    step(1, 5, 300, 1, 5);
    step(0, 0, 0, 1, 5);
    step(0, 0, 0, 1, 5);
    drain("collision");
  endtask
  initial begin
    test_reset();
    test_constant();
    test_truncation();
    test_interleave();
    test_drop();
    test_reset_mid();
    test_collision();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
